// File: rtl/stack_pkg.sv
// Shared types and defaults for the 6502 stack engine.
//   state_e   : stack sequencer states
//   op_e      : decoded request after priority encoding
//   op_select : fixed-priority request encoder (sp_load > push_word > pop_word > push > pop)
package stack_pkg;

  localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;
  localparam logic [7:0] SP_RESET_DEFAULT   = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StWrHi,
    StWrLo,
    StRdLo,
    StRdHi,
    StCap,
    StFin
  } state_e;

  typedef enum logic [2:0] {
    OpNone,
    OpLoad,
    OpPushWord,
    OpPopWord,
    OpPush,
    OpPop
  } op_e;

  function automatic op_e op_select(input logic sp_load, input logic push_word,
                                    input logic pop_word, input logic push, input logic pop);
    op_e op;
    op = OpNone;
    if (sp_load)        op = OpLoad;
    else if (push_word) op = OpPushWord;
    else if (pop_word)  op = OpPopWord;
    else if (push)      op = OpPush;
    else if (pop)       op = OpPop;
    return op;
  endfunction

endpackage

// File: rtl/stack_unit_sp_counter.sv
// 8-bit stack pointer register.
//   clk_i, reset_i : clock, asynchronous active-high reset (to RESET_VAL)
//   load_i         : load load_val_i (highest priority)
//   inc_i / dec_i  : modulo-256 increment / decrement (inc wins over dec)
//   sp_o           : current stack pointer
module sp_counter
  import stack_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = SP_RESET_DEFAULT
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] sp_o
);

  logic [7:0] sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (load_i)     sp_d = load_val_i;
    else if (inc_i) sp_d = sp_q + 8'd1;
    else if (dec_i) sp_d = sp_q - 8'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sp_q <= RESET_VAL;
    else         sp_q <= sp_d;
  end

  assign sp_o = sp_q;

endmodule

// File: rtl/stack_unit.sv
// 6502 stack engine: owns SP and sequences stack-page memory accesses.
//   push / pop            : byte push (post-decrement) / byte pop (pre-increment)
//   push_word / pop_word  : 16-bit push (high byte first) / pop (low byte first)
//   sp_load               : SP <= data_in, no memory access, no done pulse
//   sp_out, pop_data      : current SP, result of the last completed pop
//   busy, done            : operation in progress, one-cycle completion pulse
//   mem_*                 : shared synchronous memory port (read data one cycle after mem_re)
// All outputs decode from registered state and SP only.
module stack_unit
  import stack_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT,
  parameter logic [7:0] SP_RESET   = SP_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        push_word,
  input  logic        pop_word,
  input  logic        sp_load,
  input  logic [7:0]  data_in,
  input  logic [15:0] pc_in,
  output logic [7:0]  sp_out,
  output logic [15:0] pop_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata
);

  state_e      state_q, state_d;
  op_e         op;
  logic        accept;
  logic        sp_ld, sp_inc_en, sp_dec_en;
  logic [7:0]  sp, sp_plus1;
  logic [15:0] hold_q, hold_d;
  logic [15:0] pop_data_q, pop_data_d;
  logic        word_q, word_d;

  // FIN counts as idle so back-to-back requests need no gap cycle.
  assign accept   = (state_q == StIdle) || (state_q == StFin);
  assign op       = op_select(sp_load, push_word, pop_word, push, pop);
  assign sp_plus1 = sp + 8'd1;

  sp_counter #(
    .RESET_VAL (SP_RESET)
  ) u_sp_counter (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (sp_ld),
    .inc_i      (sp_inc_en),
    .dec_i      (sp_dec_en),
    .load_val_i (data_in),
    .sp_o       (sp)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StFin: begin
        state_d = StIdle;
        case (op)
          OpPushWord:       state_d = StWrHi;
          OpPush:           state_d = StWrLo;
          OpPopWord, OpPop: state_d = StRdLo;
          default:          state_d = StIdle;
        endcase
      end
      StWrHi:  state_d = StWrLo;
      StWrLo:  state_d = StFin;
      StRdLo:  state_d = word_q ? StRdHi : StCap;
      StRdHi:  state_d = StCap;
      StCap:   state_d = StFin;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    unique case (state_q)
      StWrHi: begin
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, sp};
        mem_wdata = hold_q[15:8];
      end
      StWrLo: begin
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, sp};
        mem_wdata = hold_q[7:0];
      end
      StRdLo, StRdHi: begin
        mem_re   = 1'b1;
        mem_addr = {STACK_PAGE, sp_plus1};
      end
      default: ;
    endcase
    busy = (state_q != StIdle) && (state_q != StFin);
    done = (state_q == StFin);
  end

  // SP controls and datapath registers
  always_comb begin
    sp_ld      = accept && (op == OpLoad);
    sp_dec_en  = (state_q == StWrHi) || (state_q == StWrLo);
    sp_inc_en  = (state_q == StRdLo) || (state_q == StRdHi);

    hold_d = hold_q;
    word_d = word_q;
    if (accept && (op inside {OpPushWord, OpPopWord, OpPush, OpPop})) begin
      hold_d = (op == OpPushWord) ? pc_in : {8'h00, data_in};
      word_d = (op == OpPopWord);
    end

    pop_data_d = pop_data_q;
    if (state_q == StRdHi) begin
      pop_data_d[7:0] = mem_rdata;
    end else if (state_q == StCap) begin
      pop_data_d = word_q ? {mem_rdata, pop_data_q[7:0]} : {8'h00, mem_rdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q     <= 16'h0000;
      word_q     <= 1'b0;
      pop_data_q <= 16'h0000;
    end else begin
      hold_q     <= hold_d;
      word_q     <= word_d;
      pop_data_q <= pop_data_d;
    end
  end

  assign sp_out   = sp;
  assign pop_data = pop_data_q;

endmodule
